// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache for the 8-bit
// single-cycle processor. 8 blocks of 4 bytes over a 256-byte address space,
// backed by a 32-bit-word memory that transfers one whole block at a time.
// Address split: tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [2:0]  tag_q  [8];
    logic [31:0] data_q [8];
    logic [31:0] fetchBuf_q;

    logic [2:0]  reqTag;
    logic [2:0]  reqIndex;
    logic [4:0]  byteLsb;
    logic        request;
    logic        isStore;
    logic        hit;
    logic        storeHit;
    logic        fillLine;
    logic        latchFetch;

    // A simultaneous READ and WRITE is resolved as a store, so WRITE alone
    // decides the access type whenever a request is present.
    assign reqTag   = ADDRESS[7:5];
    assign reqIndex = ADDRESS[4:2];
    assign byteLsb  = {ADDRESS[1:0], 3'b000};
    assign request  = READ | WRITE;
    assign isStore  = WRITE;
    assign hit      = valid_q[reqIndex] & (tag_q[reqIndex] == reqTag);

    // Next-state and output decode; outputs depend only on state and the current request.
    always_comb begin
        state_d       = state_q;
        READDATA      = 8'h00;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 6'h00;
        MEM_WRITEDATA = 32'h0;
        storeHit      = 1'b0;
        fillLine      = 1'b0;
        latchFetch    = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    if (hit) begin
                        if (isStore) begin
                            storeHit = 1'b1;
                        end else begin
                            READDATA = data_q[reqIndex][byteLsb +: 8];
                        end
                    end else begin
                        BUSYWAIT = 1'b1;
                        if (valid_q[reqIndex] && dirty_q[reqIndex]) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            WRITEBACK: begin
                BUSYWAIT      = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[reqIndex], reqIndex};
                MEM_WRITEDATA = data_q[reqIndex];
                if (!MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                BUSYWAIT    = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {reqTag, reqIndex};
                if (!MEM_BUSYWAIT) begin
                    latchFetch = 1'b1;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                fillLine = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and per-line valid/dirty bits; reset invalidates everything and discards dirty data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (fillLine) begin
                valid_q[reqIndex] <= 1'b1;
                dirty_q[reqIndex] <= 1'b0;
            end else if (storeHit) begin
                dirty_q[reqIndex] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset because valid gates every use of them.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (fillLine) begin
                tag_q[reqIndex]  <= reqTag;
                data_q[reqIndex] <= fetchBuf_q;
            end else if (storeHit) begin
                data_q[reqIndex][byteLsb +: 8] <= WRITEDATA;
            end
        end
    end

    // Capture the returned block only on the edge that completes the fetch.
    always_ff @(posedge CLK) begin
        if (latchFetch) begin
            fetchBuf_q <= MEM_READDATA;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed testbench for dcache, with a block memory model that
// holds each request for 5 cycles and is preloaded so that byte k of word w is w+k.
module tb_dcache;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] memArray [64];
    logic        memLoaded = 1'b0;
    int          memCnt = 0;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    // 10-time-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory answers combinationally; busy until the fifth cycle of a held request.
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (memCnt != 4);
    assign MEM_READDATA = memArray[MEM_ADDRESS];

    // Memory model: preload once, count request cycles, commit block writes on completion.
    always @(posedge CLK) begin
        if (!memLoaded) begin
            for (int w = 0; w < 64; w++) begin
                memArray[w] <= {8'(w + 3), 8'(w + 2), 8'(w + 1), 8'(w)};
            end
            memLoaded <= 1'b1;
        end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
            memArray[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
        if (RESET || !(MEM_READ || MEM_WRITE) || !MEM_BUSYWAIT) begin
            memCnt <= 0;
        end else begin
            memCnt <= memCnt + 1;
        end
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives a request just after the next rising edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = addr;
        WRITEDATA = wdata;
    endtask

    // Follows a miss until BUSYWAIT falls, profiling memory traffic; returns at the negedge of the hit cycle.
    task automatic waitForHit(output int busyCycles, output int rdCycles, output int wrCycles,
                              output logic [5:0] rdAddr, output logic [5:0] wrAddr,
                              output logic [31:0] wrData, output logic stableOk);
        logic done;
        busyCycles = 0;
        rdCycles   = 0;
        wrCycles   = 0;
        rdAddr     = 6'h00;
        wrAddr     = 6'h00;
        wrData     = 32'h0;
        stableOk   = 1'b1;
        done       = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge CLK);
            if (!BUSYWAIT) begin
                done = 1'b1;
            end else begin
                busyCycles++;
                if (MEM_READ && MEM_WRITE) stableOk = 1'b0;
                if (MEM_READ) begin
                    if (rdCycles == 0) rdAddr = MEM_ADDRESS;
                    else if (MEM_ADDRESS != rdAddr) stableOk = 1'b0;
                    rdCycles++;
                end
                if (MEM_WRITE) begin
                    if (wrCycles == 0) begin
                        wrAddr = MEM_ADDRESS;
                        wrData = MEM_WRITEDATA;
                    end else if (MEM_ADDRESS != wrAddr || MEM_WRITEDATA != wrData) begin
                        stableOk = 1'b0;
                    end
                    wrCycles++;
                end
            end
        end
        if (!done) checkOutput("missTimeout", 32'd0, 32'd1);
    endtask

    int          busyN, rdN, wrN;
    logic [5:0]  rdA, wrA;
    logic [31:0] wrD;
    logic        stab;

    // Directed scenario sequence
    initial begin
        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        checkOutput("rstBusy", 32'(BUSYWAIT), 32'd0);
        checkOutput("rstReadData", 32'(READDATA), 32'h00);
        checkOutput("rstMemRead", 32'(MEM_READ), 32'd0);
        checkOutput("rstMemWrite", 32'(MEM_WRITE), 32'd0);

        $display("[TB] cold read 0x24");
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00);
        waitForHit(busyN, rdN, wrN, rdA, wrA, wrD, stab);
        checkOutput("coldBusy", 32'(busyN), 32'd7);
        checkOutput("coldMemRead", 32'(rdN), 32'd5);
        checkOutput("coldMemWrite", 32'(wrN), 32'd0);
        checkOutput("coldMemAddr", 32'(rdA), 32'h09);
        checkOutput("coldStable", 32'(stab), 32'd1);
        checkOutput("coldData", 32'(READDATA), 32'h09);

        $display("[TB] write hit 0x25");
        applyStimulus(1'b0, 1'b1, 8'h25, 8'hAB);
        @(negedge CLK);
        checkOutput("whBusy", 32'(BUSYWAIT), 32'd0);
        checkOutput("whReadData", 32'(READDATA), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        @(negedge CLK);
        checkOutput("rh25Busy", 32'(BUSYWAIT), 32'd0);
        checkOutput("rh25Data", 32'(READDATA), 32'hAB);
        applyStimulus(1'b1, 1'b0, 8'h27, 8'h00);
        @(negedge CLK);
        checkOutput("rh27Data", 32'(READDATA), 32'h0C);

        $display("[TB] dirty eviction by read 0x44");
        applyStimulus(1'b1, 1'b0, 8'h44, 8'h00);
        waitForHit(busyN, rdN, wrN, rdA, wrA, wrD, stab);
        checkOutput("evBusy", 32'(busyN), 32'd12);
        checkOutput("evMemWrite", 32'(wrN), 32'd5);
        checkOutput("evWbAddr", 32'(wrA), 32'h09);
        checkOutput("evWbData", wrD, 32'h0C0BAB09);
        checkOutput("evMemRead", 32'(rdN), 32'd5);
        checkOutput("evFetchAddr", 32'(rdA), 32'h11);
        checkOutput("evStable", 32'(stab), 32'd1);
        checkOutput("evData", 32'(READDATA), 32'h11);

        $display("[TB] clean write miss 0x80");
        applyStimulus(1'b0, 1'b1, 8'h80, 8'h5A);
        waitForHit(busyN, rdN, wrN, rdA, wrA, wrD, stab);
        checkOutput("wmBusy", 32'(busyN), 32'd7);
        checkOutput("wmMemWrite", 32'(wrN), 32'd0);
        checkOutput("wmMemRead", 32'(rdN), 32'd5);
        checkOutput("wmFetchAddr", 32'(rdA), 32'h20);
        checkOutput("wmReadData", 32'(READDATA), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h80, 8'h00);
        @(negedge CLK);
        checkOutput("wmByte0", 32'(READDATA), 32'h5A);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
        waitForHit(busyN, rdN, wrN, rdA, wrA, wrD, stab);
        checkOutput("wm2Busy", 32'(busyN), 32'd12);
        checkOutput("wm2WbAddr", 32'(wrA), 32'h20);
        checkOutput("wm2WbData", wrD, 32'h2322215A);
        checkOutput("wm2FetchAddr", 32'(rdA), 32'h00);
        checkOutput("wm2Data", 32'(READDATA), 32'h01);

        $display("[TB] reset during fetch");
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("mfFetching", 32'(MEM_READ), 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        READ  = 1'b0;
        @(negedge CLK);
        checkOutput("mfMemRead", 32'(MEM_READ), 32'd0);
        checkOutput("mfBusy", 32'(BUSYWAIT), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00);
        waitForHit(busyN, rdN, wrN, rdA, wrA, wrD, stab);
        checkOutput("mfReBusy", 32'(busyN), 32'd7);
        checkOutput("mfReMemRead", 32'(rdN), 32'd5);
        checkOutput("mfReData", 32'(READDATA), 32'h09);
        applyStimulus(1'b1, 1'b0, 8'h25, 8'h00);
        @(negedge CLK);
        checkOutput("mfWrittenBack", 32'(READDATA), 32'hAB);

        $display("[TB] illegal read+write on hit");
        applyStimulus(1'b1, 1'b1, 8'h26, 8'h77);
        @(negedge CLK);
        checkOutput("rwBusy", 32'(BUSYWAIT), 32'd0);
        checkOutput("rwReadData", 32'(READDATA), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h26, 8'h00);
        @(negedge CLK);
        checkOutput("rwStored", 32'(READDATA), 32'h77);
        applyStimulus(1'b1, 1'b0, 8'h27, 8'h00);
        @(negedge CLK);
        checkOutput("rwNeighbour", 32'(READDATA), 32'h0C);

        applyStimulus(1'b0, 1'b0, 8'h44, 8'h00);
        @(negedge CLK);
        checkOutput("idleBusy", 32'(BUSYWAIT), 32'd0);
        checkOutput("idleReadData", 32'(READDATA), 32'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
